// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: op-type encodings, register-index width and
// the forwarding-select width helper used by decode control and the EX muxes.
package rv_pipe_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_ALU   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STORE = 2'd3
  } op_type_e;

  // One in-flight instruction as seen by the hazard tracker.
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    op_type_e op;
  } slot_t;

  function automatic int unsigned sel_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_tracker_if.sv
// Decode-side bundle for the hazard tracker: pipeline control and source
// indices in, forwarding selects / producer types / stall enable out.
interface fwd_hazard_tracker_if #(
  parameter int unsigned STAGES = 4
);
  import rv_pipe_pkg::*;

  localparam int unsigned SEL_W = sel_width(STAGES);

  logic             ADVANCE;
  logic             FLUSH;
  logic             DEC_VALID;
  reg_idx_t         RS1_SEL;
  reg_idx_t         RS2_SEL;
  reg_idx_t         RD_IN;
  logic [1:0]       TYPE_IN;
  logic [SEL_W-1:0] MUX1_SEL;
  logic [SEL_W-1:0] MUX2_SEL;
  logic [1:0]       RS1_TYPE;
  logic [1:0]       RS2_TYPE;
  logic             STALL_ENABLE;

  modport master (
    output ADVANCE, FLUSH, DEC_VALID, RS1_SEL, RS2_SEL, RD_IN, TYPE_IN,
    input  MUX1_SEL, MUX2_SEL, RS1_TYPE, RS2_TYPE, STALL_ENABLE
  );

  modport slave (
    input  ADVANCE, FLUSH, DEC_VALID, RS1_SEL, RS2_SEL, RD_IN, TYPE_IN,
    output MUX1_SEL, MUX2_SEL, RS1_TYPE, RS2_TYPE, STALL_ENABLE
  );

endinterface

// File: rtl/fwd_match.sv
// Priority match of one source register against the in-flight slots:
// youngest producing slot wins, yielding mux select, producer type and load hazard.
module fwd_match
  import rv_pipe_pkg::*;
#(
  parameter  int unsigned STAGES   = 4,
  parameter  int unsigned LOAD_LAT = 2,
  localparam int unsigned SEL_W    = sel_width(STAGES)
) (
  input  slot_t [STAGES-1:0] slots,
  input  reg_idx_t           src,
  output logic [SEL_W-1:0]   sel,
  output op_type_e           op,
  output logic               load_hazard
);

  logic [STAGES-1:0] hit;
  logic              found;

  // x0 is hard-wired zero, so it never takes a forwarded value.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      hit[i] = slots[i].valid
             && (slots[i].op == OP_ALU || slots[i].op == OP_LOAD)
             && (slots[i].rd == src)
             && (src != '0);
    end
  end

  always_comb begin
    sel         = '0;
    op          = OP_IDLE;
    load_hazard = 1'b0;
    found       = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (!found && hit[i]) begin
        found       = 1'b1;
        sel         = SEL_W'(i + 1);
        op          = slots[i].op;
        load_hazard = (slots[i].op == OP_LOAD) && (i < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// Decode-stage forwarding/hazard tracker: shifts in-flight destinations through
// STAGES slots and drives per-operand forwarding selects plus a load-use stall.
module fwd_hazard_tracker
  import rv_pipe_pkg::*;
#(
  parameter int unsigned STAGES      = 4,
  parameter int unsigned LOAD_LAT    = 2,
  parameter int unsigned FLUSH_SLOTS = 1
) (
  input logic                CLK,
  input logic                RST,
  fwd_hazard_tracker_if.slave bus
);

  slot_t [STAGES-1:0] slots;
  slot_t [STAGES-1:0] slots_nxt;
  op_type_e           op1;
  op_type_e           op2;
  logic               haz1;
  logic               haz2;
  logic               stall_en;
  logic               issue;

  fwd_match #(
    .STAGES   (STAGES),
    .LOAD_LAT (LOAD_LAT)
  ) u_match_rs1 (
    .slots       (slots),
    .src         (bus.RS1_SEL),
    .sel         (bus.MUX1_SEL),
    .op          (op1),
    .load_hazard (haz1)
  );

  fwd_match #(
    .STAGES   (STAGES),
    .LOAD_LAT (LOAD_LAT)
  ) u_match_rs2 (
    .slots       (slots),
    .src         (bus.RS2_SEL),
    .sel         (bus.MUX2_SEL),
    .op          (op2),
    .load_hazard (haz2)
  );

  assign bus.RS1_TYPE = op1;
  assign bus.RS2_TYPE = op2;

  // A redirect kills the decoded instruction anyway, so it never needs to wait.
  assign stall_en         = bus.FLUSH | ~(bus.DEC_VALID & (haz1 | haz2));
  assign bus.STALL_ENABLE = stall_en;
  assign issue            = bus.DEC_VALID & stall_en & ~bus.FLUSH;

  // Flush invalidation is applied after the optional shift, so one loop
  // covers both the advancing and the held case.
  always_comb begin
    slots_nxt = slots;
    if (bus.ADVANCE) begin
      for (int unsigned i = 1; i < STAGES; i++) begin
        slots_nxt[i] = slots[i-1];
      end
      slots_nxt[0] = '{valid: issue, rd: bus.RD_IN, op: op_type_e'(bus.TYPE_IN)};
    end
    if (bus.FLUSH) begin
      for (int unsigned i = 0; i < FLUSH_SLOTS; i++) begin
        slots_nxt[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slots <= '0;
    end else begin
      slots <= slots_nxt;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Scoreboard bench for fwd_hazard_tracker: two instances (4/2/1 and 6/3/2)
// share stimulus and are checked against a queue-based reference model.
module tb_fwd_hazard_tracker;
  import rv_pipe_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       adv, flush, dv;
  logic [4:0] rs1, rs2, rd;
  logic [1:0] typ;

  always #5 CLK = ~CLK;

  fwd_hazard_tracker_if #(.STAGES(4)) ifa ();
  fwd_hazard_tracker_if #(.STAGES(6)) ifb ();

  assign ifa.ADVANCE   = adv;
  assign ifa.FLUSH     = flush;
  assign ifa.DEC_VALID = dv;
  assign ifa.RS1_SEL   = rs1;
  assign ifa.RS2_SEL   = rs2;
  assign ifa.RD_IN     = rd;
  assign ifa.TYPE_IN   = typ;
  assign ifb.ADVANCE   = adv;
  assign ifb.FLUSH     = flush;
  assign ifb.DEC_VALID = dv;
  assign ifb.RS1_SEL   = rs1;
  assign ifb.RS2_SEL   = rs2;
  assign ifb.RD_IN     = rd;
  assign ifb.TYPE_IN   = typ;

  fwd_hazard_tracker #(.STAGES(4), .LOAD_LAT(2), .FLUSH_SLOTS(1)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (ifa.slave)
  );

  fwd_hazard_tracker #(.STAGES(6), .LOAD_LAT(3), .FLUSH_SLOTS(2)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (ifb.slave)
  );

  typedef struct {bit v; int rd; int t;} ent_t;
  typedef ent_t ent_q_t[$];
  typedef struct {int sel1; int sel2; int t1; int t2; int st;} out_t;
  typedef struct {out_t a; out_t b;} exp_t;

  exp_t   sb[$];
  exp_t   cur;
  ent_q_t ma, mb;
  int     checks = 0;
  int     errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  function automatic ent_q_t fresh(input int n);
    ent_q_t q;
    for (int i = 0; i < n; i++) q.push_back('{v: 1'b0, rd: 0, t: 0});
    return q;
  endfunction

  // Index 0 of the queue is the most recently issued instruction.
  function automatic void find(input ent_q_t q, input int src, input int lat,
                               output int sel, output int t, output bit haz);
    sel = 0; t = 0; haz = 1'b0;
    if (src != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].v && (q[i].t == 1 || q[i].t == 2) && q[i].rd == src) begin
          sel = i + 1;
          t   = q[i].t;
          haz = (q[i].t == 2) && (i < lat);
        end
      end
    end
  endfunction

  function automatic out_t predict(input ent_q_t q, input int lat);
    out_t o;
    bit   h1, h2;
    int   s, t;
    find(q, int'(rs1), lat, s, t, h1);
    o.sel1 = s; o.t1 = t;
    find(q, int'(rs2), lat, s, t, h2);
    o.sel2 = s; o.t2 = t;
    o.st = (flush || !(dv && (h1 || h2))) ? 1 : 0;
    return o;
  endfunction

  function automatic ent_q_t next_q(input ent_q_t q, input int fs, input int st_en);
    if (RST) return fresh(q.size());
    if (adv) begin
      q.push_front('{v: (dv && st_en != 0 && !flush), rd: int'(rd), t: int'(typ)});
      void'(q.pop_back());
    end
    if (flush) for (int i = 0; i < fs; i++) q[i].v = 1'b0;
    return q;
  endfunction

  task automatic drive(input bit a, input bit f, input bit d, input int r1, input int r2,
                       input int rdv, input int t, input bit r = 1'b0);
    adv = a; flush = f; dv = d;
    rs1 = 5'(r1); rs2 = 5'(r2); rd = 5'(rdv); typ = 2'(t); RST = r;
    cur.a = predict(ma, 2);
    cur.b = predict(mb, 3);
    sb.push_back(cur);
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    ma = next_q(ma, 1, cur.a.st);
    mb = next_q(mb, 2, cur.b.st);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("a_mux1", ifa.MUX1_SEL, e.a.sel1);
        chk("a_mux2", ifa.MUX2_SEL, e.a.sel2);
        chk("a_type1", ifa.RS1_TYPE, e.a.t1);
        chk("a_type2", ifa.RS2_TYPE, e.a.t2);
        chk("a_stall_en", ifa.STALL_ENABLE, e.a.st);
        chk("b_mux1", ifb.MUX1_SEL, e.b.sel1);
        chk("b_mux2", ifb.MUX2_SEL, e.b.sel2);
        chk("b_type1", ifb.RS1_TYPE, e.b.t1);
        chk("b_type2", ifb.RS2_TYPE, e.b.t2);
        chk("b_stall_en", ifb.STALL_ENABLE, e.b.st);
      end
    end
  end

  initial begin : stimulus
    RST = 1'b1; adv = 1'b0; flush = 1'b0; dv = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; typ = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    ma = fresh(4);
    mb = fresh(6);

    // reset state
    drive(0, 0, 0, 5, 7, 0, 0);
    chk("rst_mux1", ifa.MUX1_SEL, 0);
    chk("rst_mux2", ifa.MUX2_SEL, 0);
    chk("rst_type1", ifa.RS1_TYPE, 0);
    chk("rst_stall_en", ifa.STALL_ENABLE, 1);
    chk("rst_b_mux1", ifb.MUX1_SEL, 0);
    tick();

    // ALU chain: add x5 walks through every slot, then drops
    drive(1, 0, 1, 0, 0, 5, 1); tick();
    drive(1, 0, 0, 5, 0, 0, 0);
    chk("alu_fwd1", ifa.MUX1_SEL, 1);
    chk("alu_type", ifa.RS1_TYPE, 1);
    tick();
    drive(1, 0, 0, 5, 0, 0, 0); tick();
    drive(1, 0, 0, 5, 0, 0, 0); tick();
    drive(1, 0, 0, 5, 0, 0, 0);
    chk("alu_fwd4", ifa.MUX1_SEL, 4);
    tick();
    drive(1, 0, 0, 5, 0, 0, 0);
    chk("alu_drop", ifa.MUX1_SEL, 0);
    chk("alu_b_fwd5", ifb.MUX1_SEL, 5);
    tick();
    drive(1, 0, 0, 5, 0, 0, 0);
    chk("b_max_sel", ifb.MUX1_SEL, 6);
    tick();
    drive(1, 0, 0, 5, 0, 0, 0);
    chk("b_drop", ifb.MUX1_SEL, 0);
    tick();

    // load-use: lw x7 then a consumer of x7 on operand 2
    drive(1, 0, 1, 0, 0, 7, 2); tick();
    drive(1, 0, 1, 0, 7, 8, 1);
    chk("lu_stall_s0", ifa.STALL_ENABLE, 0);
    chk("lu_mux2_s0", ifa.MUX2_SEL, 1);
    chk("lu_b_stall_s0", ifb.STALL_ENABLE, 0);
    tick();
    drive(1, 0, 1, 0, 7, 8, 1);
    chk("lu_stall_s1", ifa.STALL_ENABLE, 0);
    chk("lu_b_stall_s1", ifb.STALL_ENABLE, 0);
    tick();
    drive(1, 0, 1, 0, 7, 8, 1);
    chk("lu_release", ifa.STALL_ENABLE, 1);
    chk("lu_mux2_s2", ifa.MUX2_SEL, 3);
    chk("lu_type2", ifa.RS2_TYPE, 2);
    chk("lu_b_stall_s2", ifb.STALL_ENABLE, 0);
    tick();
    drive(1, 0, 1, 0, 7, 8, 1);
    chk("lu_b_release", ifb.STALL_ENABLE, 1);
    chk("lu_b_mux2", ifb.MUX2_SEL, 4);
    tick();

    // reset in the middle of a stall
    drive(1, 0, 1, 0, 0, 7, 2); tick();
    drive(1, 0, 1, 0, 7, 0, 1, 1'b1);
    chk("rst_mid_stall", ifa.STALL_ENABLE, 0);
    tick();
    drive(1, 0, 1, 0, 7, 0, 1);
    chk("rst_release", ifa.STALL_ENABLE, 1);
    chk("rst_release_mux2", ifa.MUX2_SEL, 0);
    tick();

    // priority: x9 in slots 0 and 2, x3 in slot 1; then hold
    drive(1, 0, 1, 0, 0, 9, 1); tick();
    drive(1, 0, 1, 0, 0, 3, 1); tick();
    drive(1, 0, 1, 0, 0, 9, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 9, 3, 0, 0);
      chk("prio_hold_mux1", ifa.MUX1_SEL, 1);
      chk("prio_hold_mux2", ifa.MUX2_SEL, 2);
      tick();
    end

    // x0 never forwards
    drive(1, 0, 1, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("x0_mux1", ifa.MUX1_SEL, 0);
    tick();

    // flush without advance kills slot 0 in place
    drive(1, 0, 1, 0, 0, 4, 1); tick();
    drive(0, 1, 0, 4, 0, 0, 0);
    chk("pre_flush_mux1", ifa.MUX1_SEL, 1);
    tick();
    drive(1, 0, 1, 4, 0, 0, 0);
    chk("flush_kill", ifa.MUX1_SEL, 0);
    chk("flush_no_stall", ifa.STALL_ENABLE, 1);
    tick();

    // flush overrides a load-use stall; with advance it lands after the shift
    drive(1, 0, 1, 0, 0, 6, 2); tick();
    drive(1, 1, 1, 6, 0, 0, 1);
    chk("flush_ovr_stall", ifa.STALL_ENABLE, 1);
    tick();
    drive(0, 0, 1, 6, 0, 0, 0);
    chk("flush_adv_a_mux1", ifa.MUX1_SEL, 2);
    chk("flush_adv_a_stall", ifa.STALL_ENABLE, 0);
    chk("flush_adv_b_mux1", ifb.MUX1_SEL, 0);
    chk("flush_adv_b_stall", ifb.STALL_ENABLE, 1);
    tick();

    // randomized traffic, small register range to provoke hits
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3), $urandom_range(0, 49) == 0);
      tick();
    end
    RST = 1'b0;

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge CLK);
    chk("sb_drain", sb.size(), 0);
    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
